regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width; register count NREGS = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2: number of independent read ports, range 1..4.
REQ-004 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port reg_wr  input  1: writeback enable.
REQ-007 SHALL have port waddr  input  ADDR_W: writeback register address.
REQ-008 SHALL have port wb_data  input  DATA_W: writeback data.
REQ-009 SHALL have port raddr  input  NRD*ADDR_W: read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port rdata  output  NRD*DATA_W: read data, port i at bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port iss_vld  input  1: instruction issue, marks destination pending.
REQ-012 SHALL have port iss_addr  input  ADDR_W: destination register of issuing instruction.
REQ-013 SHALL have port rbusy  output  NRD: bit i high when raddr port i targets a pending register.
REQ-014 SHALL have port busy_cnt  output  ADDR_W+1: number of registers currently pending.

Function
REQ-015 SHALL read combinationally: rdata port i = register[raddr port i], zero latency.
REQ-016 SHALL hold register 0 at zero: reads return 0, writes and issues to address 0 ignored, register 0 never pending.
REQ-017 SHALL write wb_data into register[waddr] on the clock edge when reg_wr=1 and waddr!=0.
REQ-018 SHALL keep one busy bit per register; iss_vld=1 with iss_addr!=0 sets busy[iss_addr] at the edge.
REQ-019 SHALL clear busy[waddr] at the edge when reg_wr=1 and waddr!=0.
REQ-020 SHALL, on same-edge issue and writeback to the same address, leave busy set (new producer wins) and still write data.
REQ-021 SHALL treat writeback to a non-busy register as a plain write; busy unchanged.
REQ-022 SHALL treat issue to an already-busy register as no change to busy or busy_cnt.
REQ-023 SHALL drive rbusy port i = busy[raddr port i] (0 for address 0), subject to REQ-030.
REQ-024 SHALL update busy_cnt registered, equal to population count of busy bits after each edge: +1 per 0->1 transition, -1 per 1->0 transition, net 0 when both occur on different addresses.
REQ-025 SHALL never let busy_cnt exceed NREGS-1 nor underflow below 0.

Reset
REQ-026 SHALL, while reset=0, asynchronously clear all registers to 0, all busy bits to 0, busy_cnt to 0.
REQ-027 SHALL, with reset asserted, drive rdata all zeros and rbusy all zeros; writes and issues ignored.
REQ-028 SHALL discard pending state on reset mid-operation; first edge after deassertion behaves as normal operation.

Configuration
REQ-029 SHALL support macro REGFILE_SB_BYPASS_EN selecting write-to-read bypass.
REQ-030 SHALL, with REGFILE_SB_BYPASS_EN defined, return wb_data on any read port whose raddr equals waddr while reg_wr=1 and waddr!=0, and drive its rbusy 0.
REQ-031 SHALL, without REGFILE_SB_BYPASS_EN, return the stored value and stored busy bit; new data visible the cycle after the write edge.

Verification
REQ-032 SHALL cover reset: write 0xDEADBEEF to r5, assert reset mid-cycle -> rdata(r5)=0, busy_cnt=0 immediately, before next edge.
REQ-033 SHALL cover r0: reg_wr=1 waddr=0 wb_data=0xFFFFFFFF, iss_vld=1 iss_addr=0 -> rdata(r0)=0, rbusy=0, busy_cnt=0.
REQ-034 SHALL cover scoreboard: issue r3, then r7 -> busy_cnt=2; writeback r3=0x12 -> busy_cnt=1, rbusy(r3)=0, rbusy(r7)=1.
REQ-035 SHALL cover collision: r4 busy, same edge issue r4 and writeback r4=0x55 -> rdata(r4)=0x55, rbusy(r4)=1, busy_cnt unchanged.
REQ-036 SHALL cover bypass: r9 busy, reg_wr=1 waddr=9 wb_data=0xA5A5A5A5 with raddr port1=9 -> with macro rdata1=0xA5A5A5A5, rbusy[1]=0 same cycle; without macro old value and rbusy[1]=1 until edge.
REQ-037 SHALL cover full scoreboard: issue r1..r31 -> busy_cnt=31; further issue r10 -> busy_cnt stays 31.

Source files
------------

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Multi-read-port register file with a per-register busy
//             scoreboard. Issue marks a destination pending, writeback
//             stores data and clears the pending mark, and a registered
//             count tracks how many registers are pending. Register 0 is
//             hard-wired to zero and never pending.
//  Options  : REGFILE_SB_BYPASS_EN - when defined, a read port addressing
//             the register being written this cycle sees wb_data and a
//             clear busy flag in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,     // asynchronous, active-low
  input  logic                  reg_wr,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  iss_vld,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic [NRD-1:0]        rbusy,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  // Storage. Entry 0 is reset to zero and never written, so it reads as 0.
  logic [DATA_W-1:0] r_regs [NREGS];
  // One pending flag per register; bit 0 is never set.
  logic [NREGS-1:0]  r_busy;
  logic [CNT_W-1:0]  r_busy_cnt;

  logic w_wr_en;    // qualified writeback (address 0 filtered out)
  logic w_iss_en;   // qualified issue (address 0 filtered out)
  logic w_set;      // this edge causes a 0->1 busy transition
  logic w_clr;      // this edge causes a 1->0 busy transition

  assign w_wr_en  = reg_wr  && (waddr    != '0);
  assign w_iss_en = iss_vld && (iss_addr != '0);

  // A re-issue to an already pending register changes nothing.
  assign w_set = w_iss_en && !r_busy[iss_addr];

  // A writeback only retires the pending mark if no new producer is
  // issuing to the same register on the same edge.
  assign w_clr = w_wr_en && r_busy[waddr] &&
                 !(w_iss_en && (iss_addr == waddr));

  // Register storage update on writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[waddr] <= wb_data;
    end
  end

  // Busy scoreboard: clear on writeback, then set on issue so that a
  // same-address issue (the newer producer) overrides the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      if (w_wr_en) begin
        r_busy[waddr] <= 1'b0;
      end
      if (w_iss_en) begin
        r_busy[iss_addr] <= 1'b1;
      end
    end
  end

  // Pending count tracks transitions incrementally; it is bounded by
  // construction because w_set/w_clr only fire on real transitions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy_cnt <= '0;
    end else begin
      r_busy_cnt <= r_busy_cnt
                    + {{(CNT_W-1){1'b0}}, w_set}
                    - {{(CNT_W-1){1'b0}}, w_clr};
    end
  end

  assign busy_cnt = r_busy_cnt;

  // Read ports: combinational lookup, optional same-cycle bypass, and
  // forced zero while reset is held.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_data;
    logic              w_bsy;

    assign w_ra = raddr[gi*ADDR_W +: ADDR_W];

    // Select stored or bypassed value for this port.
    always_comb begin
      w_data = r_regs[w_ra];
      w_bsy  = r_busy[w_ra];
`ifdef REGFILE_SB_BYPASS_EN
      if (w_wr_en && (w_ra == waddr)) begin
        w_data = wb_data;
        w_bsy  = 1'b0;
      end
`endif
      if (!reset) begin
        w_data = '0;
        w_bsy  = 1'b0;
      end
    end

    assign rdata[gi*DATA_W +: DATA_W] = w_data;
    assign rbusy[gi]                  = w_bsy;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Self-checking bench for regfile_sb: directed scenarios plus
//             randomized traffic against an array-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
  localparam int NREGS  = 2 ** ADDR_W;

  logic                  clk;
  logic                  reset;
  logic                  reg_wr;
  logic [ADDR_W-1:0]     waddr;
  logic [DATA_W-1:0]     wb_data;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic                  iss_vld;
  logic [ADDR_W-1:0]     iss_addr;
  logic [NRD-1:0]        rbusy;
  logic [ADDR_W:0]       busy_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DATA_W-1:0] m_regs [NREGS];
  bit                m_busy [NREGS];

  regfile_sb #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .reg_wr   (reg_wr),
    .waddr    (waddr),
    .wb_data  (wb_data),
    .raddr    (raddr),
    .rdata    (rdata),
    .iss_vld  (iss_vld),
    .iss_addr (iss_addr),
    .rbusy    (rbusy),
    .busy_cnt (busy_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input int a);
    if (!reset || a == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
    if (reg_wr && waddr != 0 && int'(waddr) == a) return wb_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (!reset || a == 0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
    if (reg_wr && waddr != 0 && int'(waddr) == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic check_all();
    for (int p = 0; p < NRD; p++) begin
      int a;
      a = int'(raddr[p*ADDR_W +: ADDR_W]);
      check_eq($sformatf("rdata%0d", p), rdata[p*DATA_W +: DATA_W], exp_data(a));
      check_eq($sformatf("rbusy%0d", p), 32'(rbusy[p]), 32'(exp_busy(a)));
    end
    check_eq("busy_cnt", 32'(busy_cnt), reset ? 32'(model_count()) : 32'd0);
  endtask

  task automatic drive(input logic wr, input int wa, input logic [31:0] wd,
                       input logic iv, input int ia, input int ra0, input int ra1);
    reg_wr   = wr;
    waddr    = ADDR_W'(wa);
    wb_data  = wd;
    iss_vld  = iv;
    iss_addr = ADDR_W'(ia);
    raddr    = {ADDR_W'(ra1), ADDR_W'(ra0)};
  endtask

  // Check outputs mid-cycle, advance one edge, update the model.
  task automatic cyc();
    #1 check_all();
    @(posedge clk);
    if (reset) begin
      if (reg_wr && waddr != 0) begin
        m_regs[waddr] = wb_data;
        m_busy[waddr] = 1'b0;
      end
      if (iss_vld && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end else begin
      model_clear();
    end
    @(negedge clk);
  endtask

  initial begin
    int cnt_before;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    @(negedge clk);

    // Reset state
    #1 check_eq("rst_rdata", rdata[31:0], 32'd0);
    check_eq("rst_cnt", 32'(busy_cnt), 32'd0);
    cyc();
    reset = 1'b1;

    // Register 0 is immune to writes and issues
    drive(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 check_eq("r0_data", rdata[31:0], 32'd0);
    check_eq("r0_rbusy", 32'(rbusy), 32'd0);
    check_eq("r0_cnt", 32'(busy_cnt), 32'd0);
    cyc();

    // Scoreboard basic
    drive(0, 0, 0, 1, 3, 3, 7); cyc();
    drive(0, 0, 0, 1, 7, 3, 7); cyc();
    drive(0, 0, 0, 0, 0, 3, 7);
    #1 check_eq("sb_cnt2", 32'(busy_cnt), 32'd2);
    cyc();
    drive(1, 3, 32'h12, 0, 0, 3, 7); cyc();
    drive(0, 0, 0, 0, 0, 3, 7);
    #1 check_eq("sb_cnt1", 32'(busy_cnt), 32'd1);
    check_eq("sb_rbusy3", 32'(rbusy[0]), 32'd0);
    check_eq("sb_rbusy7", 32'(rbusy[1]), 32'd1);
    check_eq("sb_data3", rdata[31:0], 32'h12);
    cyc();

    // Same-edge issue and writeback collision
    drive(0, 0, 0, 1, 4, 4, 0); cyc();
    cnt_before = int'(busy_cnt);
    drive(1, 4, 32'h55, 1, 4, 4, 0); cyc();
    drive(0, 0, 0, 0, 0, 4, 0);
    #1 check_eq("col_data", rdata[31:0], 32'h55);
    check_eq("col_rbusy", 32'(rbusy[0]), 32'd1);
    check_eq("col_cnt", 32'(busy_cnt), 32'(cnt_before));
    cyc();

    // Write-to-read bypass visibility
    drive(1, 9, 32'h0000_1111, 0, 0, 0, 9); cyc();
    drive(0, 0, 0, 1, 9, 0, 9); cyc();
    drive(1, 9, 32'hA5A5_A5A5, 0, 0, 0, 9);
`ifdef REGFILE_SB_BYPASS_EN
    #1 check_eq("byp_data", rdata[63:32], 32'hA5A5_A5A5);
    check_eq("byp_rbusy", 32'(rbusy[1]), 32'd0);
`else
    #1 check_eq("byp_data", rdata[63:32], 32'h0000_1111);
    check_eq("byp_rbusy", 32'(rbusy[1]), 32'd1);
`endif
    cyc();
    drive(0, 0, 0, 0, 0, 0, 9);
    #1 check_eq("byp_after", rdata[63:32], 32'hA5A5_A5A5);
    cyc();

    // Full scoreboard and saturation of re-issue
    for (int r = 1; r < NREGS; r++) begin
      drive(0, 0, 0, 1, r, r, 0);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 check_eq("full_cnt", 32'(busy_cnt), 32'd31);
    cyc();
    drive(0, 0, 0, 1, 10, 10, 0); cyc();
    drive(0, 0, 0, 0, 0, 10, 0);
    #1 check_eq("full_reissue", 32'(busy_cnt), 32'd31);
    cyc();

    // Asynchronous reset in the middle of a cycle
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 5, 0); cyc();
    drive(0, 0, 0, 0, 0, 5, 0);
    #1 check_eq("mid_pre", rdata[31:0], 32'hDEAD_BEEF);
    #1 reset = 1'b0;
    model_clear();
    #1 check_eq("mid_rdata", rdata[31:0], 32'd0);
    check_eq("mid_cnt", 32'(busy_cnt), 32'd0);
    drive(1, 5, 32'h1234_5678, 1, 6, 5, 6);
    cyc();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 5, 6);
    cyc();

    // Randomized traffic with occasional reset pulses
    for (int n = 0; n < 1500; n++) begin
      int narrow;
      narrow = ($urandom_range(0, 3) != 0) ? 1 : 0;
      reset = ($urandom_range(0, 63) != 0);
      if (!reset) model_clear();
      drive($urandom_range(0, 1),
            narrow ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1),
            $urandom,
            $urandom_range(0, 1),
            narrow ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1),
            narrow ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1),
            narrow ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
